// File: rtl/spi_pix_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_pix_pkg : opcodes, FSM state type and pixel width for spi_pixel_loader
// Rev 1.0
// ---------------------------------------------------------------------------
package spi_pix_pkg;

  localparam int PIXEL_W = 24;

  localparam logic [7:0] OP_WRITE    = 8'h01;
  localparam logic [7:0] OP_SHOW     = 8'h02;
  localparam logic [7:0] OP_SET_LEN  = 8'h03;
  localparam logic [7:0] OP_SET_MODE = 8'h04;
  localparam logic [7:0] OP_CLR_ERR  = 8'h05;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CMD     = 4'd1,
    ST_ADDR_HI = 4'd2,
    ST_ADDR_LO = 4'd3,
    ST_PIX     = 4'd4,
    ST_LEN_HI  = 4'd5,
    ST_LEN_LO  = 4'd6,
    ST_MODE    = 4'd7,
    ST_DISCARD = 4'd8
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_pixel_loader_ssel_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ssel_sync : 3-flop SSEL synchronizer with active level and edge outputs
// Rev 1.0
// ---------------------------------------------------------------------------
module ssel_sync (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic ssel_i,
  output logic active_o,
  output logic start_o,
  output logic end_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], ssel_i};
  end

  // Clearing to "selected" keeps an SSEL that is already low at release from looking like a start.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign active_o = ~sync_q[1];
  assign start_o  = (sync_q[2:1] == 2'b10);
  assign end_o    = (sync_q[2:1] == 2'b01);

endmodule
`default_nettype wire

// File: rtl/spi_pixel_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_pixel_loader : SPI frame parser driving the NeoPixel buffer and refresh
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_pixel_loader
  import spi_pix_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int NUM_PIXELS_DEF = 60
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               ssel_i,
  input  logic [7:0]         byte_i,
  input  logic               byte_valid_i,
  output logic               wr_en_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [PIXEL_W-1:0] wr_data_o,
  output logic               refresh_req_o,
  input  logic               refresh_busy_i,
  output logic [15:0]        num_pixels_o,
  output logic [1:0]         spi_mode_o,
  output logic               err_o,
  output logic [7:0]         frame_cnt_o
);

  localparam logic [16:0] MAX_PIXELS = 17'd1 << ADDR_W;

  logic sel_active;
  logic sel_start;
  logic sel_end;

  ssel_sync u_ssel_sync (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .ssel_i   (ssel_i),
    .active_o (sel_active),
    .start_o  (sel_start),
    .end_o    (sel_end)
  );

  state_e               state_q, state_d;
  logic [15:0]          addr_q, addr_d;
  logic [1:0]           pix_cnt_q, pix_cnt_d;
  logic [7:0]           g_q, g_d;
  logic [7:0]           r_q, r_d;
  logic [7:0]           len_hi_q, len_hi_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [PIXEL_W-1:0]   wr_data_q, wr_data_d;
  logic                 refresh_req_q, refresh_req_d;
  logic                 pending_q, pending_d;
  logic [15:0]          num_pixels_q, num_pixels_d;
  logic [1:0]           spi_mode_q, spi_mode_d;
  logic                 err_q, err_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;

  logic                 byte_ok;
  logic                 show;
  logic                 want_refresh;
  logic [15:0]          len_w;

  // A strobe on the end-edge cycle still belongs to the frame, although SSEL already reads inactive.
  assign byte_ok = byte_valid_i && (state_q != ST_IDLE) && (sel_active || sel_end);
  assign len_w   = {len_hi_q, byte_i};

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_start) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (byte_ok) begin
          case (byte_i)
            OP_WRITE:    state_d = ST_ADDR_HI;
            OP_SET_LEN:  state_d = ST_LEN_HI;
            OP_SET_MODE: state_d = ST_MODE;
            default:     state_d = ST_DISCARD;
          endcase
        end
      end
      ST_ADDR_HI: if (byte_ok) state_d = ST_ADDR_LO;
      ST_ADDR_LO: if (byte_ok) state_d = ST_PIX;
      ST_PIX:     state_d = ST_PIX;
      ST_LEN_HI:  if (byte_ok) state_d = ST_LEN_LO;
      ST_LEN_LO:  if (byte_ok) state_d = ST_DISCARD;
      ST_MODE:    if (byte_ok) state_d = ST_DISCARD;
      ST_DISCARD: state_d = ST_DISCARD;
      default:    state_d = ST_IDLE;
    endcase
    if (sel_end) state_d = ST_IDLE;
  end

  always_comb begin
    addr_d       = addr_q;
    pix_cnt_d    = pix_cnt_q;
    g_d          = g_q;
    r_d          = r_q;
    len_hi_d     = len_hi_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    num_pixels_d = num_pixels_q;
    spi_mode_d   = spi_mode_q;
    err_d        = err_q;
    frame_cnt_d  = frame_cnt_q;
    show         = 1'b0;

    if (byte_ok) begin
      case (state_q)
        ST_CMD: begin
          case (byte_i)
            OP_SHOW:                          show  = 1'b1;
            OP_CLR_ERR:                       err_d = 1'b0;
            OP_WRITE, OP_SET_LEN, OP_SET_MODE: ;
            default:                          err_d = 1'b1;
          endcase
        end
        ST_ADDR_HI: addr_d[15:8] = byte_i;
        ST_ADDR_LO: begin
          addr_d[7:0] = byte_i;
          pix_cnt_d   = 2'd0;
        end
        ST_PIX: begin
          case (pix_cnt_q)
            2'd0: begin
              g_d       = byte_i;
              pix_cnt_d = 2'd1;
            end
            2'd1: begin
              r_d       = byte_i;
              pix_cnt_d = 2'd2;
            end
            default: begin
              pix_cnt_d = 2'd0;
              if (addr_q < num_pixels_q) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q[ADDR_W-1:0];
                wr_data_d = {g_q, r_q, byte_i};
              end else begin
                err_d = 1'b1;
              end
              addr_d = addr_q + 16'd1;
            end
          endcase
        end
        ST_LEN_HI: len_hi_d = byte_i;
        ST_LEN_LO: begin
          if ({1'b0, len_w} > MAX_PIXELS) begin
            num_pixels_d = MAX_PIXELS[15:0];
          end else begin
            num_pixels_d = len_w;
          end
        end
        ST_MODE: spi_mode_d = byte_i[1:0];
        default: ;
      endcase
    end

    if (sel_end && (state_q != ST_IDLE)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Requests made while the engine is busy collapse into a single deferred pulse.
  always_comb begin
    want_refresh  = show || pending_q;
    refresh_req_d = want_refresh && !refresh_busy_i;
    pending_d     = want_refresh && refresh_busy_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      addr_q        <= 16'd0;
      pix_cnt_q     <= 2'd0;
      g_q           <= 8'd0;
      r_q           <= 8'd0;
      len_hi_q      <= 8'd0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      refresh_req_q <= 1'b0;
      pending_q     <= 1'b0;
      num_pixels_q  <= 16'(NUM_PIXELS_DEF);
      spi_mode_q    <= 2'd0;
      err_q         <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      addr_q        <= addr_d;
      pix_cnt_q     <= pix_cnt_d;
      g_q           <= g_d;
      r_q           <= r_d;
      len_hi_q      <= len_hi_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      refresh_req_q <= refresh_req_d;
      pending_q     <= pending_d;
      num_pixels_q  <= num_pixels_d;
      spi_mode_q    <= spi_mode_d;
      err_q         <= err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign refresh_req_o = refresh_req_q;
  assign num_pixels_o  = num_pixels_q;
  assign spi_mode_o    = spi_mode_q;
  assign err_o         = err_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_pixel_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_pixel_loader : vector table, hand sequences and random frames vs model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_spi_pixel_loader;

  localparam int ADDR_W = 8;
  localparam int NV     = 12;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          n;
    logic [95:0] b;
    int          exp_nwr;
    logic [31:0] exp_last;
    logic        exp_err;
    logic [1:0]  exp_mode;
    logic [15:0] exp_len;
    logic [7:0]  exp_fcnt;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset_ni = 1'b0;
  logic              ssel_i = 1'b1;
  logic [7:0]        byte_i = 8'h00;
  logic              byte_valid_i = 1'b0;
  logic              refresh_busy_i = 1'b0;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [23:0]       wr_data_o;
  logic              refresh_req_o;
  logic [15:0]       num_pixels_o;
  logic [1:0]        spi_mode_o;
  logic              err_o;
  logic [7:0]        frame_cnt_o;

  spi_pixel_loader #(.ADDR_W(ADDR_W), .NUM_PIXELS_DEF(60)) dut (
    .clk_i          (clk),
    .reset_ni       (reset_ni),
    .ssel_i         (ssel_i),
    .byte_i         (byte_i),
    .byte_valid_i   (byte_valid_i),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .refresh_req_o  (refresh_req_o),
    .refresh_busy_i (refresh_busy_i),
    .num_pixels_o   (num_pixels_o),
    .spi_mode_o     (spi_mode_o),
    .err_o          (err_o),
    .frame_cnt_o    (frame_cnt_o)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_req   = 0;
  logic [31:0] act_wr[$];

  always @(negedge clk) begin
    if (wr_en_o) act_wr.push_back({wr_addr_o, wr_data_o});
    if (refresh_req_o) n_req = n_req + 1;
  end

  // Reference model: frame-level semantics of the command set.
  int          m_len;
  logic [1:0]  m_mode;
  logic        m_err;
  int          m_fcnt;
  int          m_shows;
  logic [31:0] m_wr[$];
  int          wr_base;

  task automatic model_reset();
    m_len = 60; m_mode = 2'd0; m_err = 1'b0; m_fcnt = 0; m_shows = 0;
    m_wr.delete();
  endtask

  task automatic model_frame(input bq_t q);
    logic [15:0] a;
    int          l;
    m_fcnt = (m_fcnt + 1) % 256;
    if (q.size() == 0) return;
    case (q[0])
      8'h01: if (q.size() >= 3) begin
        a = {q[1], q[2]};
        for (int k = 3; k + 2 < q.size(); k += 3) begin
          if (int'(a) < m_len) m_wr.push_back({a[7:0], q[k], q[k+1], q[k+2]});
          else m_err = 1'b1;
          a = a + 16'd1;
        end
      end
      8'h02: m_shows++;
      8'h03: if (q.size() >= 3) begin
        l = int'({q[1], q[2]});
        m_len = (l > 256) ? 256 : l;
      end
      8'h04: if (q.size() >= 2) m_mode = q[1][1:0];
      8'h05: m_err = 1'b0;
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_bytes(input bq_t q, input int maxgap);
    int g;
    foreach (q[i]) begin
      @(negedge clk);
      byte_i = q[i];
      byte_valid_i = 1'b1;
      g = $urandom_range(0, maxgap);
      if (g > 0) begin
        @(negedge clk);
        byte_valid_i = 1'b0;
        repeat (g - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic open_frame();
    @(negedge clk);
    ssel_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic close_frame();
    @(negedge clk);
    ssel_i = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_frame(input bq_t q, input int maxgap);
    open_frame();
    send_bytes(q, maxgap);
    close_frame();
  endtask

  task automatic check_vs_model(input string tag);
    int nw;
    nw = act_wr.size() - wr_base;
    chk({tag, "_nwr"}, nw, m_wr.size());
    for (int k = 0; k < nw && k < m_wr.size(); k++)
      chk({tag, "_wr"}, act_wr[wr_base + k], m_wr[k]);
    wr_base = act_wr.size();
    m_wr.delete();
    chk({tag, "_err"}, {31'd0, err_o}, {31'd0, m_err});
    chk({tag, "_mode"}, {30'd0, spi_mode_o}, {30'd0, m_mode});
    chk({tag, "_len"}, {16'd0, num_pixels_o}, m_len);
    chk({tag, "_fcnt"}, {24'd0, frame_cnt_o}, m_fcnt);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_wr_en"}, {31'd0, wr_en_o}, 32'd0);
    chk({tag, "_wr_addr"}, {24'd0, wr_addr_o}, 32'd0);
    chk({tag, "_wr_data"}, {8'd0, wr_data_o}, 32'd0);
    chk({tag, "_req"}, {31'd0, refresh_req_o}, 32'd0);
    chk({tag, "_len"}, {16'd0, num_pixels_o}, 32'd60);
    chk({tag, "_mode"}, {30'd0, spi_mode_o}, 32'd0);
    chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
    chk({tag, "_fcnt"}, {24'd0, frame_cnt_o}, 32'd0);
  endtask

  task automatic gen_frame(output bq_t q);
    int r;
    q = {};
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3: begin
        q.push_back(8'h01);
        q.push_back(($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00);
        q.push_back(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 10)) q.push_back(8'($urandom));
      end
      4: q.push_back(8'h02);
      5: begin
        q.push_back(8'h03);
        q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
        if ($urandom_range(0, 3) != 0) q.push_back(8'($urandom));
      end
      6: begin
        q.push_back(8'h04);
        q.push_back(8'($urandom));
      end
      7: q.push_back(8'h05);
      default: q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(6, 255)));
    endcase
    if (r > 3 && r != 5) repeat ($urandom_range(0, 2)) q.push_back(8'($urandom));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[NV];
    bq_t  q;
    int   nw;
    int   req0;

    vecs[0]  = '{9, 96'h01_00_05_AA_BB_CC_11_22_33_00_00_00, 2, 32'h06_112233, 1'b0, 2'd0, 16'd60, 8'd1};
    vecs[1]  = '{3, 96'h03_00_04_00_00_00_00_00_00_00_00_00, 0, 32'h0, 1'b0, 2'd0, 16'd4, 8'd2};
    vecs[2]  = '{9, 96'h01_00_03_A1_A2_A3_A4_A5_A6_00_00_00, 1, 32'h03_A1A2A3, 1'b1, 2'd0, 16'd4, 8'd3};
    vecs[3]  = '{1, 96'h05_00_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 1'b0, 2'd0, 16'd4, 8'd4};
    vecs[4]  = '{5, 96'h01_00_00_AA_BB_00_00_00_00_00_00_00, 0, 32'h0, 1'b0, 2'd0, 16'd4, 8'd5};
    vecs[5]  = '{2, 96'h04_03_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 1'b0, 2'd3, 16'd4, 8'd6};
    vecs[6]  = '{6, 96'h7F_04_00_01_02_03_00_00_00_00_00_00, 0, 32'h0, 1'b1, 2'd3, 16'd4, 8'd7};
    vecs[7]  = '{3, 96'h03_FF_FF_00_00_00_00_00_00_00_00_00, 0, 32'h0, 1'b1, 2'd3, 16'd256, 8'd8};
    vecs[8]  = '{1, 96'h05_00_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 1'b0, 2'd3, 16'd256, 8'd9};
    vecs[9]  = '{9, 96'h01_00_FF_01_02_03_04_05_06_00_00_00, 1, 32'hFF_010203, 1'b1, 2'd3, 16'd256, 8'd10};
    vecs[10] = '{2, 96'h03_01_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 1'b1, 2'd3, 16'd256, 8'd11};
    vecs[11] = '{4, 96'h03_00_0A_55_00_00_00_00_00_00_00_00, 0, 32'h0, 1'b1, 2'd3, 16'd10, 8'd12};

    model_reset();
    wr_base = 0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset_ni = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_fcnt", {24'd0, frame_cnt_o}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      q = {};
      for (int k = 0; k < vecs[i].n; k++) q.push_back(vecs[i].b[95 - 8*k -: 8]);
      send_frame(q, 0);
      model_frame(q);
      m_wr.delete();
      nw = act_wr.size() - wr_base;
      chk($sformatf("vec%0d_nwr", i), nw, vecs[i].exp_nwr);
      if (vecs[i].exp_nwr > 0)
        chk($sformatf("vec%0d_last_wr", i), (nw > 0) ? act_wr[act_wr.size() - 1] : 32'hDEAD_BEEF, vecs[i].exp_last);
      chk($sformatf("vec%0d_err", i), {31'd0, err_o}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_mode", i), {30'd0, spi_mode_o}, {30'd0, vecs[i].exp_mode});
      chk($sformatf("vec%0d_len", i), {16'd0, num_pixels_o}, {16'd0, vecs[i].exp_len});
      chk($sformatf("vec%0d_fcnt", i), {24'd0, frame_cnt_o}, {24'd0, vecs[i].exp_fcnt});
      wr_base = act_wr.size();
    end

    // Final B byte lands on the end-edge cycle and must still be written.
    open_frame();
    send_bytes('{8'h01, 8'h00, 8'h07, 8'h11, 8'h22}, 0);
    @(negedge clk); ssel_i = 1'b1;
    @(negedge clk);
    @(negedge clk); byte_i = 8'h33; byte_valid_i = 1'b1;
    @(negedge clk); byte_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    model_frame('{8'h01, 8'h00, 8'h07, 8'h11, 8'h22, 8'h33});
    check_vs_model("endedge");

    // SHOW with the engine idle: pulse the cycle after the strobe.
    req0 = n_req;
    open_frame();
    @(negedge clk); byte_i = 8'h02; byte_valid_i = 1'b1;
    @(negedge clk); byte_valid_i = 1'b0;
    chk("show_req_high", {31'd0, refresh_req_o}, 32'd1);
    @(negedge clk);
    chk("show_req_low", {31'd0, refresh_req_o}, 32'd0);
    close_frame();
    chk("show_pulses", n_req - req0, 32'd1);
    model_frame('{8'h02});

    // Two SHOWs while busy coalesce into one pulse after busy falls.
    req0 = n_req;
    refresh_busy_i = 1'b1;
    send_frame('{8'h02}, 0);
    send_frame('{8'h02, 8'h02}, 0);
    model_frame('{8'h02});
    model_frame('{8'h02, 8'h02});
    chk("busy_no_req", n_req - req0, 32'd0);
    @(negedge clk); refresh_busy_i = 1'b0;
    @(negedge clk);
    chk("busy_req_high", {31'd0, refresh_req_o}, 32'd1);
    @(negedge clk);
    chk("busy_req_low", {31'd0, refresh_req_o}, 32'd0);
    repeat (10) @(negedge clk);
    chk("busy_pulses", n_req - req0, 32'd1);
    check_vs_model("busy");

    // Randomized frames against the model.
    req0 = n_req;
    m_shows = 0;
    for (int f = 0; f < 50; f++) begin
      gen_frame(q);
      send_frame(q, 1);
      model_frame(q);
      check_vs_model($sformatf("rnd%0d", f));
    end
    chk("rnd_refresh_count", n_req - req0, m_shows);

    // Reset in the middle of a pixel with SSEL held low.
    send_frame('{8'h04, 8'h01}, 0);
    send_frame('{8'hEE}, 0);
    open_frame();
    send_bytes('{8'h01, 8'h00, 8'h00, 8'hAA}, 0);
    @(negedge clk); reset_ni = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("midrst");
    reset_ni = 1'b1;
    model_reset();
    wr_base = act_wr.size();
    repeat (4) @(negedge clk);
    send_bytes('{8'hBB, 8'hCC, 8'h01, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33}, 0);
    repeat (3) @(negedge clk);
    chk("midrst_no_wr", act_wr.size() - wr_base, 32'd0);
    close_frame();
    chk("midrst_fcnt", {24'd0, frame_cnt_o}, 32'd0);
    send_frame('{8'h04, 8'h02}, 0);
    model_frame('{8'h04, 8'h02});
    check_vs_model("postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_pixel_loader.md
# spi_pixel_loader

Frame-level controller between the SPI byte receiver and the NeoPixel pixel buffer/serializer. Parses each SPI frame (one SSEL-low period) into a command and its payload, writes GRB pixel data into the pixel buffer, sets the strip length, reconfigures the receiver's SPI mode, and schedules refreshes of the NeoPixel output engine without overlapping a refresh in progress.

## Interface
- ADDR_W, 8, pixel buffer address width; buffer depth is 2^ADDR_W.
- NUM_PIXELS_DEF, 60, reset value of num_pixels_o.

- clk_i  in  1  system clock; the only clock.
- reset_ni  in  1  reset, synchronous, active-low.
- ssel_i  in  1  raw SPI slave select, active low, asynchronous to clk_i.
- byte_i  in  8  received byte, valid with byte_valid_i.
- byte_valid_i  in  1  one-cycle strobe per received byte.
- wr_en_o  out  1  pixel buffer write strobe.
- wr_addr_o  out  ADDR_W  pixel buffer write address.
- wr_data_o  out  24  pixel word {G,R,B}, G in [23:16].
- refresh_req_o  out  1  one-cycle pulse starting a strip refresh.
- refresh_busy_i  in  1  high while the output engine is refreshing.
- num_pixels_o  out  16  configured strip length.
- spi_mode_o  out  2  SPI mode driven to the byte receiver.
- err_o  out  1  sticky protocol error flag.
- frame_cnt_o  out  8  count of completed frames, wraps at 255.

## Operation
- ssel_i passes through a 3-flop synchronizer. Active = ~sync[1]; start edge = sync[2:1]==2'b10; end edge = sync[2:1]==2'b01.
- Bytes arriving while SSEL is inactive are ignored.
- FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, PIX, LEN_HI, LEN_LO, MODE, DISCARD.
- IDLE -> CMD on the start edge. First byte in CMD selects the opcode:
  - 0x01 WRITE: ADDR_HI -> ADDR_LO (16-bit big-endian start address) -> PIX.
  - 0x02 SHOW: request a refresh, then DISCARD.
  - 0x03 SET_LEN: LEN_HI -> LEN_LO. num_pixels_o is loaded at LEN_LO, clamped to 2^ADDR_W, then DISCARD.
  - 0x04 SET_MODE: MODE. spi_mode_o <= byte[1:0], then DISCARD.
  - 0x05 CLR_ERR: err_o <= 0, then DISCARD.
  - Any other opcode: err_o <= 1, then DISCARD.
- PIX: a 2-bit byte counter (0..2) assembles G, R, B. On the third byte:
  - Write the pixel if the address is < num_pixels_o; otherwise suppress the write and set err_o.
  - Address increments modulo 2^16.
- DISCARD ignores all bytes until the end edge.
- End edge in any state: go to IDLE and increment frame_cnt_o if the frame reached CMD or beyond. A partial pixel, or a partial SET_LEN with only one byte received, is dropped with no effect.
- Byte strobe coinciding with the end edge: the byte's effect commits first, then the next state is IDLE.
- Refresh scheduling:
  - SHOW with refresh_busy_i low: pulse refresh_req_o.
  - SHOW while busy: set a pending flag, and pulse in the first cycle busy is low.
  - Multiple SHOWs while pending coalesce into one refresh.
  - A pending refresh survives frame boundaries.
- Reset state: FSM IDLE; wr_en_o=0, wr_addr_o=0, wr_data_o=0, refresh_req_o=0, pending=0, num_pixels_o=NUM_PIXELS_DEF, spi_mode_o=0, err_o=0, frame_cnt_o=0.
- Reset mid-frame aborts the frame. After reset releases, the FSM waits for a fresh start edge; an already-low SSEL is not a start.

## Timing
- Start edge is seen 2–3 clk_i cycles after the ssel_i fall.
- wr_en_o, wr_addr_o and wr_data_o are registered. wr_en_o is high exactly one cycle, the cycle after the strobe of the B byte.
- refresh_req_o rises the cycle after the SHOW byte strobe when not busy. Otherwise it rises the cycle after refresh_busy_i is first sampled low.
- spi_mode_o, num_pixels_o and err_o update the cycle after the relevant byte strobe.
- Back-to-back byte strobes on consecutive cycles must be accepted.

## Structure
- Package spi_pix_pkg: opcode constants (OP_WRITE=8'h01 … OP_CLR_ERR=8'h05), FSM state typedef, PIXEL_W=24.
- One sub-module: ssel_sync, which contains the 3-flop synchronizer plus active, start-edge and end-edge outputs.
- The FSM, address counter and refresh scheduler live in the top module.

## Test plan
- Frame 01 00 05 AA BB CC 11 22 33 -> writes {AA,BB,CC}@5 then {11,22,33}@6, frame_cnt_o=1, err_o=0.
- SET_LEN 03 00 04, then WRITE 01 00 03 with 6 pixel bytes -> write @3 only; @4 suppressed; err_o=1; CLR_ERR frame 05 -> err_o=0.
- SHOW 02 while refresh_busy_i=1, second SHOW before busy falls -> exactly one refresh_req_o pulse, in the cycle after busy falls.
- WRITE frame ended after 01 00 00 AA BB -> no write, FSM IDLE, frame_cnt_o increments.
- SET_MODE 04 03 -> spi_mode_o=2'b11. Then opcode 7F -> err_o=1, and all trailing bytes in that frame are ignored.
- reset_ni low mid-PIX with SSEL held low -> all outputs at reset values. Bytes are ignored until SSEL rises and falls again.
